// File: rtl/inst_encoder_pkg.sv
// Shared encoding constants for the instruction encoder and the matching
// decoder. Kind codes select the request format; opcode constants are the
// fixed low bits placed in word[3:0]; the immediate widths are the signed
// field widths each format can carry.
package inst_encoder_pkg;

    // Request kinds
    localparam logic [2:0] KIND_RTYPE = 3'd0;
    localparam logic [2:0] KIND_ADDI  = 3'd1;
    localparam logic [2:0] KIND_LW    = 3'd2;
    localparam logic [2:0] KIND_SW    = 3'd3;
    localparam logic [2:0] KIND_BEQ   = 3'd4;
    localparam logic [2:0] KIND_BGT   = 3'd5;
    localparam logic [2:0] KIND_JAL   = 3'd6;

    // Base opcodes (word[3:0]); SW and JAL carry an immediate bit in word[3]
    localparam logic [3:0] OPC_ADDI   = 4'b0001;
    localparam logic [3:0] OPC_LW     = 4'b1001;
    localparam logic [2:0] OPC_SW_LO  = 3'b010;
    localparam logic [3:0] OPC_BEQ    = 4'b0011;
    localparam logic [3:0] OPC_BGT    = 4'b1011;
    localparam logic [2:0] OPC_JAL_LO = 3'b100;

    // Signed immediate field widths
    localparam int IMM_W_I = 4;   // ADDI / LW
    localparam int IMM_W_S = 5;   // SW
    localparam int IMM_W_B = 4;   // BEQ / BGT
    localparam int IMM_W_J = 9;   // JAL

    // True when the 16-bit two's complement value fits in a signed field of
    // 'width' bits: every bit from width-1 upward must equal the sign bit.
    function automatic logic imm_fits(input logic [15:0] imm, input int width);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if ((i >= width - 1) && (imm[i] != imm[15]))
                ok = 1'b0;
        end
        return ok;
    endfunction

    // RTYPE opcodes whose low three bits collide with the I/S/B/J formats
    function automatic logic rtype_opc_reserved(input logic [3:0] opc);
        return (opc[2:0] >= 3'b001) && (opc[2:0] <= 3'b100);
    endfunction

endpackage

// File: rtl/inst_fifo2.sv
// Two-entry first-in first-out buffer with valid/ready on both sides.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset (empties FIFO)
//   wr_valid/wr_ready/wr_data   write side; wr_ready = not full
//   rd_valid/rd_ready/rd_data   read side; rd_data is the head entry
module inst_fifo2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_reg [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        count_reg;
    logic              wr_fire;
    logic              rd_fire;

    assign wr_ready = (count_reg != 2'd2);
    assign rd_valid = (count_reg != 2'd0);
    assign rd_data  = mem_reg[rd_ptr_reg];
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_valid && rd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++)
                mem_reg[i] <= '0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (wr_fire) begin
                mem_reg[wr_ptr_reg] <= wr_data;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (rd_fire)
                rd_ptr_reg <= ~rd_ptr_reg;
            // Push and pop together leave the occupancy unchanged
            case ({wr_fire, rd_fire})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: turns structured requests into 16-bit instruction
// words, rejects malformed requests, buffers words in a 2-entry FIFO and
// pairs each outgoing word with a sequential write address.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, base_addr  reload address counter and clear error count
//   in_*              request handshake and fields
//   out_valid/out_ready/out_inst/out_addr   word output to instruction memory
//   err_pulse, err_cnt                      rejection flag and saturating count
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [3:0]        in_opc,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [15:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ERR_W-1:0]  ERR_ONE  = 1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;

    logic [15:0]       enc_inst;
    logic              enc_ok;
    logic              reject;
    logic              pop;
    logic [ADDR_W-1:0] addr_reg;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic              err_pulse_reg;

    // Field placement mirrors the core's immediate-generation scheme
    always_comb begin
        enc_inst = '0;
        enc_ok   = 1'b0;
        case (in_kind)
            KIND_RTYPE: begin
                enc_inst = {in_rs2, in_rs1, in_rd, in_opc};
                enc_ok   = !rtype_opc_reserved(in_opc);
            end
            KIND_ADDI: begin
                enc_inst = {in_imm[3:0], in_rs1, in_rd, OPC_ADDI};
                enc_ok   = imm_fits(in_imm, IMM_W_I);
            end
            KIND_LW: begin
                enc_inst = {in_imm[3:0], in_rs1, in_rd, OPC_LW};
                enc_ok   = imm_fits(in_imm, IMM_W_I);
            end
            KIND_SW: begin
                // imm[0] rides in the top opcode bit
                enc_inst = {in_rs2, in_rs1, in_imm[4:1], in_imm[0], OPC_SW_LO};
                enc_ok   = imm_fits(in_imm, IMM_W_S);
            end
            KIND_BEQ: begin
                enc_inst = {in_rs2, in_rs1, in_imm[3:0], OPC_BEQ};
                enc_ok   = imm_fits(in_imm, IMM_W_B);
            end
            KIND_BGT: begin
                enc_inst = {in_rs2, in_rs1, in_imm[3:0], OPC_BGT};
                enc_ok   = imm_fits(in_imm, IMM_W_B);
            end
            KIND_JAL: begin
                // imm[8] rides in the top opcode bit
                enc_inst = {in_imm[7:4], in_imm[3:0], in_rd, in_imm[8], OPC_JAL_LO};
                enc_ok   = imm_fits(in_imm, IMM_W_J);
            end
            default: begin
                enc_inst = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // A rejected request still completes the handshake but never reaches the FIFO
    assign reject = in_valid && in_ready && !enc_ok;
    assign pop    = out_valid && out_ready;

    inst_fifo2 #(
        .DATA_W (16)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (in_valid && enc_ok),
        .wr_ready (in_ready),
        .wr_data  (enc_inst),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (out_inst)
    );

    // Address is stamped when a word leaves; start overrides the increment so
    // a coincident pop uses the old address and the next word gets base_addr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            addr_reg <= '0;
        else if (start)
            addr_reg <= base_addr;
        else if (pop)
            addr_reg <= addr_reg + ADDR_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg   <= '0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= reject;
            if (start)
                err_cnt_reg <= '0;
            else if (reject && (err_cnt_reg != ERR_MAX))
                err_cnt_reg <= err_cnt_reg + ERR_ONE;
        end
    end

    assign out_addr  = addr_reg;
    assign err_pulse = err_pulse_reg;
    assign err_cnt   = err_cnt_reg;

endmodule
